// File: rtl/obi_arb_pkg.sv
// obi_arb_pkg: shared state type, ID-width helper and default depth for the
// OBI round-robin arbiter and its response-routing FIFO.
package obi_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   // Default number of granted-but-unanswered transactions tracked.
   localparam int OBI_ARB_MAX_OUTSTANDING = 4;

   // Width of a requester ID: at least one bit even for a single requester.
   function automatic int id_w(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// obi_arb_id_fifo: synchronous in-order FIFO holding the requester ID of each
// granted transaction until its response returns. Push and pop may occur in
// the same cycle; push is ignored when full and pop is ignored when empty.
module obi_arb_id_fifo
   import obi_arb_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = OBI_ARB_MAX_OUTSTANDING
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
         else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
      end
   end

   // Storage write.
   // NOTE: the storage array is deliberately not reset; the pointers and count
   // define which entries are valid, so resetting the array only costs area.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: shares one downstream OBI target among NUM_REQ upstream
// requesters. Round-robin on the request/grant phase, request locked until
// granted, in-order response routing through an ID FIFO.
// Build option: define OBI_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer); default is round-robin.
module obi_rr_arbiter
   import obi_arb_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int OBI_ADDRW       = 32,
   parameter int OBI_DATAW       = 32,
   parameter int OBI_STRBW       = OBI_DATAW / 8,
   parameter int MAX_OUTSTANDING = OBI_ARB_MAX_OUTSTANDING
) (
   input  logic                                  clk_i,
   input  logic                                  srst_i,
   input  logic [NUM_REQ-1:0]                    up_req_i,
   input  logic [NUM_REQ-1:0][OBI_ADDRW-1:0]     up_addr_i,
   input  logic [NUM_REQ-1:0]                    up_we_i,
   input  logic [NUM_REQ-1:0][OBI_DATAW-1:0]     up_wdata_i,
   input  logic [NUM_REQ-1:0][OBI_STRBW-1:0]     up_be_i,
   output logic [NUM_REQ-1:0]                    up_gnt_o,
   output logic [NUM_REQ-1:0]                    up_rvalid_o,
   output logic [NUM_REQ-1:0][OBI_DATAW-1:0]     up_rdata_o,
   output logic                                  dn_req_o,
   output logic [OBI_ADDRW-1:0]                  dn_addr_o,
   output logic                                  dn_we_o,
   output logic [OBI_DATAW-1:0]                  dn_wdata_o,
   output logic [OBI_STRBW-1:0]                  dn_be_o,
   input  logic                                  dn_gnt_i,
   input  logic                                  dn_rvalid_i,
   input  logic [OBI_DATAW-1:0]                  dn_rdata_i,
   output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
   output logic                                  err_o
);

   localparam int ID_W = id_w(NUM_REQ);

   arb_state_e          state_q;
   arb_state_e          state_d;
   logic [ID_W-1:0]     lock_idx_q;
   logic [ID_W-1:0]     winner_idx;
   logic [ID_W-1:0]     sel_idx;
   logic [ID_W-1:0]     head_idx;
   logic [NUM_REQ-1:0]  pick_vec;
   logic                win_valid;
   logic                grant;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic                err_q;

`ifdef OBI_ARB_FIXED_PRIO_EN
   assign pick_vec = up_req_i;
`else
   logic [ID_W-1:0]     rr_ptr_q;
   logic [NUM_REQ-1:0]  req_hi;

   // Requests at or above the pointer take precedence; otherwise wrap to the full vector.
   always_comb begin
      req_hi = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_hi[i] = up_req_i[i] && (ID_W'(i) >= rr_ptr_q);
      end
   end

   assign pick_vec = (|req_hi) ? req_hi : up_req_i;

   // Pointer moves to one past each granted requester, wrapping at NUM_REQ.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         rr_ptr_q <= '0;
      end else if (grant) begin
         rr_ptr_q <= (sel_idx == ID_W'(NUM_REQ - 1)) ? '0 : sel_idx + ID_W'(1);
      end
   end
`endif

   // Winner is the lowest set bit of the (possibly masked) request vector.
   // NOTE: combinational blocks use blocking '=' so later statements see earlier
   // results; every output is given a default first so no latch is inferred.
   always_comb begin
      winner_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pick_vec[i]) winner_idx = ID_W'(i);
      end
   end

   // A new arbitration is only allowed while the ID FIFO has room.
   assign win_valid = (|up_req_i) && !fifo_full;

   // State and locked-winner registers.
   // NOTE: sequential blocks use non-blocking '<=' so all registers update
   // together from pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q    <= ARB_IDLE;
         lock_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ARB_IDLE && win_valid && !dn_gnt_i) lock_idx_q <= winner_idx;
      end
   end

   // Next state: lock an ungranted winner, release the lock on grant.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (win_valid && !dn_gnt_i) state_d = ARB_LOCK;
         ARB_LOCK: if (dn_gnt_i)               state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // Downstream request, payload mux and upstream grant; all quiet during reset.
   always_comb begin
      dn_req_o   = 1'b0;
      sel_idx    = winner_idx;
      dn_addr_o  = '0;
      dn_we_o    = 1'b0;
      dn_wdata_o = '0;
      dn_be_o    = '0;
      up_gnt_o   = '0;
      if (!srst_i) begin
         if (state_q == ARB_LOCK) begin
            dn_req_o = 1'b1;
            sel_idx  = lock_idx_q;
         end else begin
            dn_req_o = win_valid;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (dn_req_o && sel_idx == ID_W'(i)) begin
            dn_addr_o   = up_addr_i[i];
            dn_we_o     = up_we_i[i];
            dn_wdata_o  = up_wdata_i[i];
            dn_be_o     = up_be_i[i];
            up_gnt_o[i] = dn_gnt_i;
         end
      end
   end

   assign grant = dn_req_o && dn_gnt_i;

   // A response only pops when an ID is already queued; a same-cycle grant does not count.
   assign pop = dn_rvalid_i && !fifo_empty && !srst_i;

   // Response routing: the FIFO head owns the current response, others see zero data.
   always_comb begin
      up_rvalid_o = '0;
      up_rdata_o  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pop && head_idx == ID_W'(i)) begin
            up_rvalid_o[i] = 1'b1;
            up_rdata_o[i]  = dn_rdata_i;
         end
      end
   end

   // Sticky error: a response arrived with nothing outstanding.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         err_q <= 1'b0;
      end else if (dn_rvalid_i && fifo_empty) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

   obi_arb_id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .push_i  (grant),
      .data_i  (sel_idx),
      .pop_i   (pop),
      .data_o  (head_idx),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (outstanding_o)
   );

endmodule

// File: doc/obi_rr_arbiter.md
# obi_rr_arbiter

Shares one downstream OBI target port, normally the `obi_2_axi` bridge input, between `NUM_REQ` upstream OBI requesters such as the two cores and a debug or DMA master. It arbitrates round-robin on the request/grant phase. It keeps requests locked until granted, so the downstream address phase stays stable. It records the granted requester ID in an in-order FIFO and routes each `rvalid_i`/`rdata_i` back to the requester that owns it.

## Interface
- `NUM_REQ`, 2, number of upstream requesters (2..8)
- `OBI_ADDRW`, 32, address width
- `OBI_DATAW`, 32, data width
- `OBI_STRBW`, `OBI_DATAW/8`, byte-enable width
- `MAX_OUTSTANDING`, 4, granted-but-unanswered transactions tracked (power of 2, ≥2)

Ports:
- `clk_i`  in  1  single clock for all logic
- `srst_i`  in  1  synchronous, active-high reset
- `up_req_i`  in  `NUM_REQ`  per-requester OBI req
- `up_addr_i`  in  `NUM_REQ`×`OBI_ADDRW`  per-requester address
- `up_we_i`  in  `NUM_REQ`  per-requester write enable
- `up_wdata_i`  in  `NUM_REQ`×`OBI_DATAW`  per-requester write data
- `up_be_i`  in  `NUM_REQ`×`OBI_STRBW`  per-requester byte enable
- `up_gnt_o`  out  `NUM_REQ`  per-requester grant
- `up_rvalid_o`  out  `NUM_REQ`  per-requester response valid
- `up_rdata_o`  out  `NUM_REQ`×`OBI_DATAW`  per-requester read data
- `dn_req_o`, `dn_addr_o`, `dn_we_o`, `dn_wdata_o`, `dn_be_o`  out  as above  downstream request
- `dn_gnt_i`  in  1  downstream grant
- `dn_rvalid_i`  in  1  downstream response valid
- `dn_rdata_i`  in  `OBI_DATAW`  downstream read data
- `outstanding_o`  out  `$clog2(MAX_OUTSTANDING)+1`  current FIFO occupancy
- `err_o`  out  1  sticky: `dn_rvalid_i` arrived while no transaction was outstanding

## Operation
- State machine `ARB_IDLE` / `ARB_LOCK`.
- In `ARB_IDLE`:
  - If any `up_req_i` is set and occupancy < `MAX_OUTSTANDING`, the winner is the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `dn_req_o`=1. `dn_*` carry the winner's payload combinationally.
- Winner granted in the same cycle (`dn_gnt_i`=1): `up_gnt_o[winner]`=1, winner ID pushed, `rr_ptr` ← winner+1 (wraps), stay `ARB_IDLE`.
- Winner not granted: the winner index is registered and the state moves to `ARB_LOCK`.
- In `ARB_LOCK`:
  - The locked index drives `dn_*`. Other requests are ignored and `dn_req_o`=1.
  - On `dn_gnt_i`: grant, push, advance `rr_ptr`, return to `ARB_IDLE`.
- FIFO full: `dn_req_o`=0 and every `up_gnt_o`=0 in `ARB_IDLE`. `ARB_LOCK` is never entered when full.
- Response routing:
  - On `dn_rvalid_i`, FIFO head *h* gets `up_rvalid_o[h]`=1 and `up_rdata_o[h]`=`dn_rdata_i`, then the FIFO pops.
  - `up_rdata_o` of every non-addressed requester is 0.
- Push and pop in the same cycle: occupancy unchanged, both take effect.
- `dn_rvalid_i` with an empty FIFO: response dropped, `err_o`←1 until reset.
- `gnt_i` and `rvalid_i` in the same cycle for the same transaction is illegal under OBI; `rvalid_i` is treated as the empty-FIFO case.

## Timing
- Reset (`srst_i` sampled high at an edge):
  - state `ARB_IDLE`, `rr_ptr`=0, FIFO empty, `err_o`=0, `outstanding_o`=0.
  - All `up_gnt_o`, `up_rvalid_o`, `up_rdata_o`, `dn_req_o`, `dn_*` = 0 while reset is held.
- Reset mid-operation discards outstanding IDs. Later stray `dn_rvalid_i` sets `err_o`.
- Latencies:
  - `up_req_i` → `dn_req_o`: 0 cycles in `ARB_IDLE`.
  - `dn_gnt_i` → `up_gnt_o`: 0 cycles.
  - `dn_rvalid_i` → `up_rvalid_o`: 0 cycles.
- `outstanding_o` updates at the edge after push/pop.
- `dn_addr_o`, `dn_we_o`, `dn_wdata_o` and `dn_be_o` are stable from `dn_req_o` rise until `dn_gnt_i`.

## Configuration
- `OBI_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins, `rr_ptr` is not implemented.
- Undefined (default): round-robin as above.
- Lock, FIFO and routing behaviour are identical in both modes.

## Structure
- `obi_arb_pkg` holds:
  - `arb_state_e` (`ARB_IDLE`, `ARB_LOCK`)
  - function `id_w(n)` = max(1, `$clog2(n)`)
  - the default `MAX_OUTSTANDING` constant
- Sub-module `obi_arb_id_fifo`: synchronous FIFO, width `id_w(NUM_REQ)`, depth `MAX_OUTSTANDING`, with push/pop/full/empty/count outputs and simultaneous push+pop allowed.

## Test plan
- Reset: hold `srst_i` 3 cycles with `up_req_i`=2'b11 → all outputs 0; `dn_req_o` rises the first cycle after release.
- Contention: both requesters request continuously, `dn_gnt_i`=1 → grants alternate 0,1,0,1. With `OBI_ARB_FIXED_PRIO_EN`, always 0.
- Lock: req0 addr 0xAB, `dn_gnt_i` held low 3 cycles while req1 rises → `dn_addr_o` stays 0xAB, and the grant goes to 0 on cycle 4.
- In-order return: grants 0,1,0, then `rvalid_i` with data 0x11, 0x22, 0x33 → req0 gets 0x11 and 0x33, req1 gets 0x22.
- Full: 4 grants with no rvalid → 5th request sees `dn_req_o`=0 and `outstanding_o`=4. One rvalid → 5th request is issued next cycle.
- Error: `dn_rvalid_i` pulse with an empty FIFO → `err_o`=1 and stays 1 until `srst_i`.
